// File: rtl/print_arbiter.sv
// print_arbiter: round-robin owner-locked arbiter sharing one character-print sink among NREQ requesters.
// Define PRINT_ARB_TIMEOUT_EN to release a stalled owner after TMO idle cycles (adds tmo_flag port).

module print_arb_lane #(
    parameter int CW = 8
) (
    input  logic          sel,
    input  logic          req,
    input  logic [CW-1:0] chr,
    input  logic          last,
    input  logic          ready,
    output logic          valid,
    output logic [CW-1:0] chr_fwd,
    output logic          last_fwd,
    output logic          ack
);
    // Everything is zero unless this lane owns the grant, so the top can simply OR lanes together.
    assign valid    = sel & req;
    assign chr_fwd  = sel ? chr : '0;
    assign last_fwd = sel & last;
    assign ack      = sel & req & ready;
endmodule

module print_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8,
    parameter int TMO  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_char,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    output logic [CW-1:0]      out_char,
    output logic               out_last,
    input  logic               out_ready,
    output logic [2:0]         out_owner,
    output logic [15:0]        msg_count
`ifdef PRINT_ARB_TIMEOUT_EN
    ,
    output logic               tmo_flag
`endif
);
    if (NREQ < 2 || NREQ > 8 || TMO < 1) begin : g_cfg_check
        $error("print_arbiter: unsupported NREQ or TMO");
    end

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state, state_n;
    logic [NREQ-1:0]         gnt_n;
    logic [2:0]              ptr, ptr_n, owner_n, win, nxt;
    logic [15:0]             cnt_n;
    logic                    take;
    logic [NREQ-1:0]         lane_valid, lane_last;
    logic [NREQ-1:0][CW-1:0] lane_char;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        print_arb_lane #(.CW(CW)) u_lane (
            .sel      (gnt[i]),
            .req      (req[i]),
            .chr      (req_char[i*CW +: CW]),
            .last     (req_last[i]),
            .ready    (out_ready),
            .valid    (lane_valid[i]),
            .chr_fwd  (lane_char[i]),
            .last_fwd (lane_last[i]),
            .ack      (ack[i])
        );
    end

    always_comb begin
        out_char = '0;
        for (int i = 0; i < NREQ; i++) out_char = out_char | lane_char[i];
    end

    assign out_valid = |lane_valid;
    assign out_last  = |lane_last;
    assign take      = out_valid & out_ready;

    // Scan downward so the candidate closest to ptr (smallest offset) is assigned last and wins.
    always_comb begin
        int idx;
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) win = 3'(idx);
        end
    end

    assign nxt = (out_owner == 3'(NREQ - 1)) ? 3'd0 : out_owner + 3'd1;

`ifdef PRINT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] stall_cnt, stall_cnt_n;
    logic          tmo_hit;

    assign tmo_hit = (state == LOCK) && !out_valid && (stall_cnt == TW'(TMO - 1));

    always_comb begin
        stall_cnt_n = '0;
        if (state == LOCK && !out_valid && !tmo_hit) stall_cnt_n = stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            tmo_flag  <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_n;
            tmo_flag  <= tmo_hit;
        end
    end
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        owner_n = out_owner;
        ptr_n   = ptr;
        cnt_n   = msg_count;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = LOCK;
                    gnt_n   = NREQ'(1) << win;
                    owner_n = win;
                end
            end
            LOCK: begin
                if (take && out_last) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    owner_n = '0;
                    ptr_n   = nxt;
                    cnt_n   = msg_count + 16'd1;
                end
`ifdef PRINT_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    owner_n = '0;
                    ptr_n   = nxt;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                owner_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            out_owner <= '0;
            ptr       <= '0;
            msg_count <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            out_owner <= owner_n;
            ptr       <= ptr_n;
            msg_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_print_arbiter.sv
// Bench for print_arbiter: arbitration table, directed corner sequences and a randomized
// message-level round-robin reference model.

module tb_print_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 8;
    localparam int TMO  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req, req_last, ack, gnt;
    logic [NREQ*CW-1:0] req_char;
    logic               out_valid, out_last, out_ready;
    logic [CW-1:0]      out_char;
    logic [2:0]         out_owner;
    logic [15:0]        msg_count;
`ifdef PRINT_ARB_TIMEOUT_EN
    logic               tmo_flag;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    print_arbiter #(.NREQ(NREQ), .CW(CW), .TMO(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_char  (req_char),
        .req_last  (req_last),
        .ack       (ack),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_last  (out_last),
        .out_ready (out_ready),
        .out_owner (out_owner),
        .msg_count (msg_count)
`ifdef PRINT_ARB_TIMEOUT_EN
        ,
        .tmo_flag  (tmo_flag)
`endif
    );

    typedef struct {
        int              prime;
        logic [NREQ-1:0] mask;
        int              win;
    } arb_vec_t;

    typedef struct packed {
        logic [CW-1:0] c;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [2:0]    o;
        logic [CW-1:0] c;
        logic          l;
    } exp_t;

    arb_vec_t   tbl[10];
    beat_t      rq[NREQ][$];
    beat_t      mq[NREQ][$];
    exp_t       expq[$];
    exp_t       e;
    beat_t      b;
    logic [7:0] bp[3];
    logic       rdy_seq[5];
    int         rr_exp[4];
    int         ci, acks, ntake, tmo_seen, first_g1, nmsg, p, w, budget;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [CW-1:0] c, input logic l);
        req[i]               = v;
        req_char[i*CW +: CW] = c;
        req_last[i]          = l;
    endtask

    task automatic idle_all();
        req      = '0;
        req_last = '0;
        req_char = '0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{-1, 4'b1011, 0};
        tbl[1] = '{ 0, 4'b1011, 1};
        tbl[2] = '{ 1, 4'b1011, 3};
        tbl[3] = '{ 3, 4'b1011, 0};
        tbl[4] = '{-1, 4'b0100, 2};
        tbl[5] = '{ 2, 4'b0100, 2};
        tbl[6] = '{ 3, 4'b0110, 1};
        tbl[7] = '{ 1, 4'b1000, 3};
        tbl[8] = '{ 2, 4'b0011, 0};
        tbl[9] = '{-1, 4'b1000, 3};
        bp      = '{8'h41, 8'h42, 8'h43};
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rr_exp  = '{0, 1, 3, 0};
        out_ready = 1'b0;

        // single message "Hi" from requester 2, including reset state
        do_reset();
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_char", out_char, 0);
        chk("rst_last", out_last, 0);
        chk("rst_owner", out_owner, 0);
        chk("rst_msgcnt", msg_count, 0);
        drive(2, 1'b1, 8'h48, 1'b0);
        out_ready = 1'b1;
        #2;
        chk("hi_latency", out_valid, 0);
        step();
        #2;
        chk("hi_gnt", gnt, 4'b0100);
        chk("hi_owner", out_owner, 2);
        chk("hi_valid", out_valid, 1);
        chk("hi_char0", out_char, 8'h48);
        chk("hi_ack0", ack, 4'b0100);
        step();
        drive(2, 1'b1, 8'h69, 1'b1);
        #2;
        chk("hi_char1", out_char, 8'h69);
        chk("hi_last", out_last, 1);
        chk("hi_ack1", ack, 4'b0100);
        step();
        idle_all();
        #2;
        chk("hi_idle_gnt", gnt, 0);
        chk("hi_msgcnt", msg_count, 1);
        chk("hi_idle_valid", out_valid, 0);

        // arbitration table: optional priming message sets ptr, then a request mask
        for (int v = 0; v < 10; v++) begin
            do_reset();
            if (tbl[v].prime >= 0) begin
                drive(tbl[v].prime, 1'b1, 8'h50, 1'b1);
                out_ready = 1'b1;
                step();
                step();
                idle_all();
            end
            out_ready = 1'b0;
            for (int i = 0; i < NREQ; i++)
                if (tbl[v].mask[i]) drive(i, 1'b1, 8'(8'h30 + i), 1'b1);
            step();
            #2;
            chk("tbl_gnt", gnt, 1 << tbl[v].win);
            chk("tbl_owner", out_owner, tbl[v].win);
            out_ready = 1'b1;
            step();
            idle_all();
            step();
        end

        // contention with continuous 1-char messages from 0, 1 and 3
        do_reset();
        drive(0, 1'b1, 8'h10, 1'b1);
        drive(1, 1'b1, 8'h11, 1'b1);
        drive(3, 1'b1, 8'h13, 1'b1);
        out_ready = 1'b1;
        ntake = 0;
        for (int c = 0; c < 20 && ntake < 4; c++) begin
            step();
            #2;
            chk("rr_onehot", $onehot0(gnt), 1);
            if (out_valid && out_ready) begin
                chk("rr_order", out_owner, rr_exp[ntake]);
                chk("rr_char", out_char, 8'(8'h10 + rr_exp[ntake]));
                ntake++;
            end
        end
        chk("rr_count", ntake, 4);

        // backpressure: owner 1 sends A,B,C while out_ready goes 1,0,0,1,1
        do_reset();
        ci = 0;
        acks = 0;
        drive(1, 1'b1, bp[0], 1'b0);
        out_ready = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            out_ready = rdy_seq[c];
            #2;
            chk("bp_char", out_char, bp[ci]);
            chk("bp_last", out_last, ci == 2);
            chk("bp_ack", ack, out_ready ? 4'b0010 : 4'b0000);
            if (ack[1]) acks++;
            if (out_ready) ci++;
            step();
            if (ci < 3) drive(1, 1'b1, bp[ci], ci == 2);
            else idle_all();
        end
        #2;
        chk("bp_acks", acks, 3);
        chk("bp_msgcnt", msg_count, 1);
        chk("bp_gnt", gnt, 0);

        // reset mid-message; ptr is 2 here, so a post-reset winner of 0 shows ptr was cleared
        drive(0, 1'b1, 8'h58, 1'b0);
        out_ready = 1'b1;
        step();
        #2;
        chk("mr_gnt", gnt, 4'b0001);
        step();
        drive(0, 1'b1, 8'h59, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_gnt0", gnt, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_msgcnt", msg_count, 0);
        chk("mr_owner", out_owner, 0);
        step();
        reset = 1'b0;
        idle_all();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 8'h20, 1'b1);
        step();
        #2;
        chk("mr_ptr0", gnt, 4'b0001);

        // owner 0 stalls for 20 cycles mid-message while requester 1 waits
        do_reset();
        drive(0, 1'b1, 8'h53, 1'b0);
        drive(1, 1'b1, 8'h54, 1'b1);
        out_ready = 1'b1;
        step();
        #2;
        chk("st_gnt", gnt, 4'b0001);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        out_ready = 1'b0;
        tmo_seen = 0;
        first_g1 = -1;
        for (int s = 1; s <= 20; s++) begin
            step();
            #2;
`ifdef PRINT_ARB_TIMEOUT_EN
            if (tmo_flag) begin
                tmo_seen++;
                chk("tmo_cycle", s, 16);
            end
            if (gnt == 4'b0010 && first_g1 < 0) first_g1 = s;
`else
            chk("st_hold_gnt", gnt, 4'b0001);
            chk("st_hold_valid", out_valid, 0);
            chk("st_hold_ack", ack, 0);
`endif
        end
`ifdef PRINT_ARB_TIMEOUT_EN
        chk("tmo_pulses", tmo_seen, 1);
        chk("tmo_next", first_g1, 17);
        chk("tmo_msgcnt", msg_count, 0);
`else
        drive(0, 1'b1, 8'h55, 1'b1);
        out_ready = 1'b1;
        #2;
        chk("st_resume", out_char, 8'h55);
        step();
        drive(0, 1'b0, 8'h00, 1'b0);
        step();
        #2;
        chk("st_next", gnt, 4'b0010);
        chk("st_msgcnt", msg_count, 1);
`endif

        // randomized rounds against a message-level round-robin model
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                rq[i].delete();
                for (int m = $urandom_range(1, 5); m > 0; m--) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        b.c = 8'($urandom);
                        b.l = (k == len - 1);
                        rq[i].push_back(b);
                    end
                end
                mq[i] = rq[i];
            end
            expq.delete();
            p = 0;
            nmsg = 0;
            forever begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && mq[(p + k) % NREQ].size() > 0) w = (p + k) % NREQ;
                if (w < 0) break;
                do begin
                    b = mq[w].pop_front();
                    e.o = 3'(w);
                    e.c = b.c;
                    e.l = b.l;
                    expq.push_back(e);
                end while (!b.l);
                nmsg++;
                p = (w + 1) % NREQ;
            end

            do_reset();
            budget = 0;
            while (expq.size() > 0 && budget < 3000) begin
                for (int i = 0; i < NREQ; i++)
                    if (rq[i].size() > 0) drive(i, 1'b1, rq[i][0].c, rq[i][0].l);
                    else drive(i, 1'b0, 8'h00, 1'b0);
                out_ready = ($urandom_range(0, 3) != 0);
                #2;
                chk("rnd_onehot", $onehot0(gnt), 1);
                if (out_valid && out_ready) begin
                    e = expq.pop_front();
                    chk("rnd_owner", out_owner, e.o);
                    chk("rnd_char", out_char, e.c);
                    chk("rnd_last", out_last, e.l);
                    chk("rnd_ack", ack, 1 << e.o);
                    if (rq[e.o].size() > 0) void'(rq[e.o].pop_front());
                end else begin
                    chk("rnd_noack", ack, 0);
                end
                step();
                budget++;
            end
            if (expq.size() > 0) chk("rnd_budget", expq.size(), 0);
            idle_all();
            #2;
            chk("rnd_msgcnt", msg_count, nmsg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
